// File: rtl/seq_detect_param.sv
// Parametrised serial pattern detector with run-time loadable pattern, fill guard,
// overlap/non-overlap modes and saturating match counter. Optional mask: SEQ_DETECT_MASK_EN.
module seq_detect_param #(
   parameter int unsigned       PAT_W   = 4,
   parameter int unsigned       CNT_W   = 8,
   parameter logic [PAT_W-1:0]  RST_PAT = PAT_W'(4'b1001)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             seq_valid,
   input  logic             seq,
   input  logic             overlap,
   input  logic             pat_load,
   input  logic [PAT_W-1:0] pat_in,
`ifdef SEQ_DETECT_MASK_EN
   input  logic [PAT_W-1:0] pat_mask_in,
`endif
   input  logic             cnt_clr,
   output logic             detect,
   output logic [CNT_W-1:0] match_cnt,
   output logic             cnt_sat
);

   localparam int unsigned      FILL_W    = $clog2(PAT_W + 1);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

   if (PAT_W < 2 || PAT_W > 32) begin : g_pat_w_check
      $error("seq_detect_param: PAT_W must be in 2..32");
   end

   logic [PAT_W-1:0]  shift_q, shift_d;
   logic [FILL_W-1:0] fill_q, fill_d;
   logic [PAT_W-1:0]  pat_q, pat_d;
   logic              detect_q, detect_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              sat_q, sat_d;
`ifdef SEQ_DETECT_MASK_EN
   logic [PAT_W-1:0]  mask_q, mask_d;
`endif

   logic [PAT_W-1:0]  window_c;
   logic [FILL_W-1:0] fill_inc_c;
   logic [PAT_W-1:0]  diff_c;
   logic              match_c;

   // Candidate window including the bit sampled on this edge; fill guard uses post-edge fill.
   always_comb begin
      window_c   = {shift_q[PAT_W-2:0], seq};
      fill_inc_c = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + FILL_W'(1);
`ifdef SEQ_DETECT_MASK_EN
      diff_c     = (window_c ^ pat_q) & mask_q;
`else
      diff_c     = window_c ^ pat_q;
`endif
      match_c    = seq_valid && !pat_load && (fill_inc_c == FILL_FULL) && (diff_c == '0);
   end

   always_comb begin
      shift_d  = shift_q;
      fill_d   = fill_q;
      pat_d    = pat_q;
      detect_d = match_c;
      cnt_d    = cnt_q;
`ifdef SEQ_DETECT_MASK_EN
      mask_d   = mask_q;
`endif
      if (pat_load) begin
         pat_d   = pat_in;
`ifdef SEQ_DETECT_MASK_EN
         mask_d  = pat_mask_in;
`endif
         shift_d = '0;
         fill_d  = '0;
      end else if (seq_valid) begin
         shift_d = window_c;
         // Non-overlap mode restarts the fill guard so the next match needs fresh bits.
         fill_d  = (match_c && !overlap) ? '0 : fill_inc_c;
      end

      if (cnt_clr) begin
         cnt_d = '0;
      end else if (match_c && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
      sat_d = (cnt_d == CNT_MAX);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_q  <= '0;
         fill_q   <= '0;
         pat_q    <= RST_PAT;
         detect_q <= 1'b0;
         cnt_q    <= '0;
         sat_q    <= 1'b0;
`ifdef SEQ_DETECT_MASK_EN
         mask_q   <= '1;
`endif
      end else begin
         shift_q  <= shift_d;
         fill_q   <= fill_d;
         pat_q    <= pat_d;
         detect_q <= detect_d;
         cnt_q    <= cnt_d;
         sat_q    <= sat_d;
`ifdef SEQ_DETECT_MASK_EN
         mask_q   <= mask_d;
`endif
      end
   end

   assign detect    = detect_q;
   assign match_cnt = cnt_q;
   assign cnt_sat   = sat_q;

endmodule

// File: doc/seq_detect_param.md
Name: seq_detect_param

Overview:
Parametrised serial pattern detector and the successor to the fixed 4-bit shift-register detector.
- Pattern width is set by a parameter; the pattern itself is loaded at run time.
- Input bits are qualified by a valid strobe.
- Overlapping or non-overlapping match mode is selectable.
- A fill guard blocks false matches after reset or pattern load.
- A saturating match counter is provided.
- Sits on serial framing/sync-word paths, between bit deserialisers and frame-alignment control.

Parameters:
PAT_W, 4, pattern length in bits; legal range 2..32.
CNT_W, 8, width of the match counter.
RST_PAT, 4'b1001 (PAT_W bits), pattern value after reset.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
seq_valid  input  1  seq is sampled on an edge only when high.
seq  input  1  serial data bit.
overlap  input  1  1 = overlapping matches; 0 = non-overlapping.
pat_load  input  1  load pat_in as the new pattern.
pat_in  input  PAT_W  new pattern; MSB is the oldest bit.
cnt_clr  input  1  synchronous clear of match_cnt.
detect  output  1  registered one-cycle match pulse.
match_cnt  output  CNT_W  number of matches, saturating.
cnt_sat  output  1  high while match_cnt is all-ones.

Behaviour:
- Reset (rst_n low, asynchronous):
  - shift = 0, fill = 0, pattern = RST_PAT.
  - detect = 0, match_cnt = 0, cnt_sat = 0.
- Internal state:
  - shift[PAT_W-1:0]: newest bit at the LSB.
  - fill: count of valid bits received, 0..PAT_W, saturating at PAT_W.
- On an edge with seq_valid = 1 and pat_load = 0:
  - shift <= {shift[PAT_W-2:0], seq}.
  - fill <= min(fill+1, PAT_W).
- Match condition (evaluated on that edge):
  - {shift[PAT_W-2:0], seq} == pattern, and
  - fill_next == PAT_W.
- Fill guard: no detect until PAT_W valid bits have arrived since reset or pattern load. This holds even for an all-zero pattern.
- detect:
  - Registered: detect <= match.
  - High for exactly the one cycle after the edge that sampled the completing bit. Latency is 1 clock.
  - A back-to-back match in consecutive valid cycles gives consecutive detect pulses (overlap mode only).
- overlap = 1: after a match, shift and fill continue normally.
- overlap = 0: on a match edge, fill <= 0 while shift still shifts. The next match needs PAT_W fresh bits.
- overlap is sampled each edge. Changing it mid-stream affects only future match edges.
- seq_valid = 0: shift, fill and pattern hold; detect <= 0.
- pat_load = 1:
  - pattern <= pat_in; shift <= 0; fill <= 0; detect <= 0.
  - A seq_valid bit in the same cycle is discarded (pat_load has priority).
- match_cnt:
  - Increments on every match edge.
  - Holds at 2^CNT_W-1 when saturated; no wrap.
  - cnt_sat is derived combinationally from match_cnt == all-ones.
- cnt_clr = 1: match_cnt <= 0. If a match happens in the same cycle, clear wins and the count is 0. detect still pulses.
- Reset mid-stream: all state is cleared immediately. The stream must refill PAT_W bits before any detect.

Optional Feature:
- Macro: SEQ_DETECT_MASK_EN.
- When defined:
  - Adds input pat_mask_in [PAT_W-1:0], loaded together with pat_in on pat_load.
  - The mask resets to all-ones.
  - Bit i = 0 makes position i don't-care.
  - Match compares only ((window ^ pattern) & mask) == 0. The fill guard still applies.
- When undefined: no port and no mask register; an exact compare is used.

Test Plan:
- Reset, default pattern 1001, overlap = 1, seq = 1,0,0,1,0,0,1 with valid every cycle -> detect pulses the cycle after bits 4 and 7; match_cnt = 2.
- Same stream, overlap = 0 -> detect only after bit 4; match_cnt = 1.
- pat_load with pat_in = 0000, then seq = 0 x3 -> no detect; 4th 0 -> detect. Continuous 0s in overlap mode -> detect every cycle.
- Stream 1,0,0,1 with seq_valid low for 3 cycles between each bit -> single detect, one cycle after the 4th valid bit; idle bits are ignored.
- CNT_W = 2, five matches -> match_cnt reaches 3 and holds; cnt_sat = 1. cnt_clr asserted on a match edge -> match_cnt = 0, detect = 1.
- rst_n pulled low after bits 1,0,0 of 1001, then released and 1 sent -> no detect. Full 1,0,0,1 -> detect. With SEQ_DETECT_MASK_EN and mask 1001, stream 1,1,1,1 -> detect.
